// File: rtl/tdc_pkg.sv
// Shared types for the TDC scan controller: coarse-time width,
// scan FSM state encodings and a small counter helper.
package tdc_pkg;

    localparam int CT_W = 8;

    typedef logic [CT_W-1:0] ct_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_RUN,
        S_WAIT_ACCEPT,
        S_WAIT_FINISH,
        S_ADVANCE,
        S_DONE,
        S_ERROR
    } scan_state_e;

    // Highest counter index for a count where 0 encodes 256.
    function automatic ct_t last_idx(ct_t n);
        return n - ct_t'(1);
    endfunction

endpackage

// File: rtl/tdc_scan_controller_if.sv
// Sequencer handshake and RAM write port of the TDC scan controller.
interface tdc_scan_controller_if
    import tdc_pkg::*;
#(
    parameter int ADDR_W = 10
) ();

    logic              seq_ready;
    logic              seq_write;
    logic              seq_run;
    ct_t               seq_t_start;
    ct_t               seq_t_stop;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    modport master (
        input  seq_ready, seq_write,
        output seq_run, seq_t_start, seq_t_stop,
        output ram_addr, ram_we
    );

    modport slave (
        output seq_ready, seq_write,
        input  seq_run, seq_t_start, seq_t_stop,
        input  ram_addr, ram_we
    );

endinterface

// File: rtl/tdc_ram_addr_gen.sv
// Turns seq_write rising edges into single-cycle RAM writes and
// advances the address, saturating with an overflow flag at the top.
module tdc_ram_addr_gen #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              seq_write,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic write_q;
    logic rise;

    assign rise = seq_write & ~write_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            overflow <= 1'b0;
        end else begin
            write_q <= seq_write;
            if (clear) begin
                ram_we   <= 1'b0;
                ram_addr <= '0;
                overflow <= 1'b0;
            end else begin
                ram_we <= rise & ~overflow;
                // last slot is written, then the address parks there
                if (ram_we) begin
                    if (ram_addr == ADDR_MAX)
                        overflow <= 1'b1;
                    else
                        ram_addr <= ram_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tdc_scan_controller.sv
// Steps a TDC sequencer through a grid of stop times with repeats,
// tracking RAM writes and flagging timeouts and overflow.
module tdc_scan_controller
    import tdc_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic scan_start,
    input  logic scan_abort,
    input  ct_t  t_start_base,
    input  ct_t  t_stop_first,
    input  ct_t  t_stop_step,
    input  ct_t  n_steps,
    input  ct_t  n_repeats,
    tdc_scan_controller_if.master bus,
    output logic busy,
    output logic done,
    output logic error,
    output logic overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    scan_state_e   state_q, state_d;
    ct_t           t_start_q, t_stop_q, t_step_q;
    ct_t           n_steps_q, n_rep_q, step_q, rep_q;
    logic          abort_q;
    logic [TW-1:0] tmo_q;
    logic          latch, inc_rep, inc_step, tmo_inc, tmo_hit;

    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        inc_rep  = 1'b0;
        inc_step = 1'b0;
        tmo_inc  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (scan_start) begin
                    state_d = S_WAIT_READY;
                    latch   = 1'b1;
                end
            end
            S_WAIT_READY: if (bus.seq_ready) state_d = S_RUN;
            S_RUN:        state_d = S_WAIT_ACCEPT;
            S_WAIT_ACCEPT: begin
                tmo_inc = 1'b1;
                if (!bus.seq_ready) state_d = S_WAIT_FINISH;
                else if (tmo_hit)   state_d = S_ERROR;
            end
            S_WAIT_FINISH: begin
                tmo_inc = 1'b1;
                if (bus.seq_ready) state_d = S_ADVANCE;
                else if (tmo_hit)  state_d = S_ERROR;
            end
            S_ADVANCE: begin
                if (abort_q || scan_abort || overflow) begin
                    state_d = S_DONE;
                end else if (rep_q < last_idx(n_rep_q)) begin
                    inc_rep = 1'b1;
                    state_d = S_WAIT_READY;
                end else if (step_q < last_idx(n_steps_q)) begin
                    inc_step = 1'b1;
                    state_d  = S_WAIT_READY;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_start_q <= '0;
            t_stop_q  <= '0;
            t_step_q  <= '0;
            n_steps_q <= '0;
            n_rep_q   <= '0;
            step_q    <= '0;
            rep_q     <= '0;
            abort_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if (latch) begin
                t_start_q <= t_start_base;
                t_stop_q  <= t_stop_first;
                t_step_q  <= t_stop_step;
                n_steps_q <= n_steps;
                n_rep_q   <= n_repeats;
                step_q    <= '0;
                rep_q     <= '0;
                abort_q   <= 1'b0;
            end else if (state_q != S_IDLE && scan_abort) begin
                abort_q <= 1'b1;
            end
            if (inc_rep) rep_q <= rep_q + 1'b1;
            // running sum keeps stop = first + step*inc, wrapping mod 256
            if (inc_step) begin
                rep_q    <= '0;
                step_q   <= step_q + 1'b1;
                t_stop_q <= t_stop_q + t_step_q;
            end
            if (state_q == S_RUN)        tmo_q <= '0;
            else if (tmo_inc && !tmo_hit) tmo_q <= tmo_q + 1'b1;
        end
    end

    tdc_ram_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (latch),
        .seq_write (bus.seq_write),
        .ram_we    (bus.ram_we),
        .ram_addr  (bus.ram_addr),
        .overflow  (overflow)
    );

    assign bus.seq_run     = (state_q == S_RUN);
    assign bus.seq_t_start = t_start_q;
    assign bus.seq_t_stop  = t_stop_q;

    assign busy  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done  = (state_q == S_DONE);
    assign error = (state_q == S_ERROR);

endmodule

// File: tb/tb_tdc_scan_controller.sv
// Scoreboard bench: a sequencer model answers run pulses, expected
// stop times are queued at stimulus time and compared per run.
module tb_tdc_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, start_b, scan_abort;
    logic [7:0] t_start_base, t_stop_first, t_stop_step;
    logic [7:0] n_steps, n_repeats;
    logic       seq_ready, seq_write;
    logic       busy_a, done_a, err_a, ovf_a;
    logic       busy_b, done_b, err_b, ovf_b;

    bit sel;
    int wpr;
    bit hang;
    int checks = 0;
    int passed = 0;
    int runs = 0;
    int we_cnt = 0;
    int unstable = 0;
    logic [7:0] obs_stop [64];
    logic [7:0] run_stop;
    logic [7:0] exp_q [$];

    tdc_scan_controller_if #(.ADDR_W(10)) ifa ();
    tdc_scan_controller_if #(.ADDR_W(4))  ifb ();

    assign ifa.seq_ready = seq_ready;
    assign ifa.seq_write = seq_write;
    assign ifb.seq_ready = seq_ready;
    assign ifb.seq_write = seq_write;

    tdc_scan_controller #(.ADDR_W(10), .TIMEOUT_CYC(1023)) dut_a (
        .clk(clk), .reset(reset), .scan_start(start_a), .scan_abort(scan_abort),
        .t_start_base(t_start_base), .t_stop_first(t_stop_first),
        .t_stop_step(t_stop_step), .n_steps(n_steps), .n_repeats(n_repeats),
        .bus(ifa), .busy(busy_a), .done(done_a), .error(err_a), .overflow(ovf_a)
    );

    tdc_scan_controller #(.ADDR_W(4), .TIMEOUT_CYC(1023)) dut_b (
        .clk(clk), .reset(reset), .scan_start(start_b), .scan_abort(scan_abort),
        .t_start_base(t_start_base), .t_stop_first(t_stop_first),
        .t_stop_step(t_stop_step), .n_steps(n_steps), .n_repeats(n_repeats),
        .bus(ifb), .busy(busy_b), .done(done_b), .error(err_b), .overflow(ovf_b)
    );

    logic       run_o, we_o, busy_o, done_o, err_o, ovf_o;
    logic [9:0] addr_o;
    logic [7:0] tst_o, tsp_o;

    assign run_o  = sel ? ifb.seq_run : ifa.seq_run;
    assign we_o   = sel ? ifb.ram_we : ifa.ram_we;
    assign busy_o = sel ? busy_b : busy_a;
    assign done_o = sel ? done_b : done_a;
    assign err_o  = sel ? err_b : err_a;
    assign ovf_o  = sel ? ovf_b : ovf_a;
    assign addr_o = sel ? {6'd0, ifb.ram_addr} : ifa.ram_addr;
    assign tst_o  = sel ? ifb.seq_t_start : ifa.seq_t_start;
    assign tsp_o  = sel ? ifb.seq_t_stop : ifa.seq_t_stop;

    // sequencer model: drop ready on a run, write wpr times, raise ready
    typedef enum int {M_IDLE, M_WR, M_GAP, M_TAIL, M_HANG} m_e;
    initial begin
        m_e m = M_IDLE;
        int wcnt = 0;
        int tail = 0;
        forever begin
            @(posedge clk);
            #2;
            if (we_o) we_cnt++;
            if (reset) begin
                m = M_IDLE;
                seq_ready = 1'b1;
                seq_write = 1'b0;
            end else begin
                case (m)
                    M_IDLE: begin
                        seq_ready = 1'b1;
                        seq_write = 1'b0;
                        if (run_o) begin
                            obs_stop[runs % 64] = tsp_o;
                            run_stop = tsp_o;
                            runs++;
                            seq_ready = 1'b0;
                            wcnt = 0;
                            m = hang ? M_HANG : M_WR;
                        end
                    end
                    M_WR: begin
                        seq_write = 1'b1;
                        m = M_GAP;
                    end
                    M_GAP: begin
                        seq_write = 1'b0;
                        wcnt++;
                        if (wcnt >= wpr) begin
                            tail = 3;
                            m = M_TAIL;
                        end else begin
                            m = M_WR;
                        end
                    end
                    M_TAIL: begin
                        tail--;
                        if (tail == 0) begin
                            seq_ready = 1'b1;
                            m = M_IDLE;
                        end
                    end
                    default: begin
                        if (!hang) begin
                            seq_ready = 1'b1;
                            m = M_IDLE;
                        end
                    end
                endcase
                if (m inside {M_WR, M_GAP, M_TAIL} && tsp_o !== run_stop) unstable++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_scan(input bit s, input logic [7:0] ts, input logic [7:0] fs,
                              input logic [7:0] st, input logic [7:0] ns, input logic [7:0] nr);
        @(negedge clk);
        sel = s;
        t_start_base = ts;
        t_stop_first = fs;
        t_stop_step = st;
        n_steps = ns;
        n_repeats = nr;
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_end(input int lim, output bit to);
        to = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done_o || err_o) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_runs(input int target, input int lim, output bit to);
        to = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (runs >= target) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_o); else passed++;
        checks++; if (done_o !== 1'b0) $display("FAIL rst_done: got %0b want 0", done_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL rst_error: got %0b want 0", err_o); else passed++;
        checks++; if (ovf_o !== 1'b0) $display("FAIL rst_overflow: got %0b want 0", ovf_o); else passed++;
        checks++; if (run_o !== 1'b0) $display("FAIL rst_run: got %0b want 0", run_o); else passed++;
        checks++; if (we_o !== 1'b0) $display("FAIL rst_we: got %0b want 0", we_o); else passed++;
        checks++; if (addr_o !== 10'd0) $display("FAIL rst_addr: got %0d want 0", addr_o); else passed++;
        checks++; if (tsp_o !== 8'd0) $display("FAIL rst_tstop: got %0d want 0", tsp_o); else passed++;
        checks++; if (tst_o !== 8'd0) $display("FAIL rst_tstart: got %0d want 0", tst_o); else passed++;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic check_stops(input string name, input int r0);
        int i = 0;
        while (exp_q.size() > 0) begin
            logic [7:0] e = exp_q.pop_front();
            logic [7:0] g = obs_stop[(r0 + i) % 64];
            checks++;
            if (g !== e) $display("FAIL %s_stop%0d: got %0d want %0d", name, i, g, e);
            else passed++;
            i++;
        end
    endtask

    task automatic test_grid;
        int r0 = runs;
        int w0 = we_cnt;
        int u0 = unstable;
        bit to;
        wpr = 8;
        for (int s = 0; s < 3; s++)
            for (int r = 0; r < 2; r++) exp_q.push_back(8'(10 + 5 * s));
        start_scan(1'b0, 8'd33, 8'd10, 8'd5, 8'd3, 8'd2);
        wait_end(3000, to);
        checks++; if (to !== 1'b0) $display("FAIL grid_timeout: got %0b want 0", to); else passed++;
        checks++; if (done_o !== 1'b1) $display("FAIL grid_done: got %0b want 1", done_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL grid_busy: got %0b want 0", busy_o); else passed++;
        checks++; if (addr_o !== 10'd48) $display("FAIL grid_addr: got %0d want 48", addr_o); else passed++;
        checks++; if (we_cnt - w0 !== 48) $display("FAIL grid_we: got %0d want 48", we_cnt - w0); else passed++;
        checks++; if (runs - r0 !== 6) $display("FAIL grid_runs: got %0d want 6", runs - r0); else passed++;
        checks++; if (tst_o !== 8'd33) $display("FAIL grid_tstart: got %0d want 33", tst_o); else passed++;
        checks++; if (unstable - u0 !== 0) $display("FAIL grid_stable: got %0d want 0", unstable - u0); else passed++;
        check_stops("grid", r0);
    endtask

    task automatic test_wrap;
        int r0 = runs;
        bit to;
        wpr = 1;
        for (int s = 0; s < 3; s++) exp_q.push_back(8'(250 + 4 * s));
        start_scan(1'b0, 8'd0, 8'd250, 8'd4, 8'd3, 8'd1);
        wait_end(1000, to);
        checks++; if (to !== 1'b0) $display("FAIL wrap_timeout: got %0b want 0", to); else passed++;
        checks++; if (runs - r0 !== 3) $display("FAIL wrap_runs: got %0d want 3", runs - r0); else passed++;
        checks++; if (addr_o !== 10'd3) $display("FAIL wrap_addr: got %0d want 3", addr_o); else passed++;
        check_stops("wrap", r0);
    endtask

    task automatic test_overflow;
        int r0 = runs;
        int w0 = we_cnt;
        bit to;
        wpr = 8;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        start_scan(1'b1, 8'd0, 8'd0, 8'd1, 8'd3, 8'd1);
        wait_end(2000, to);
        checks++; if (to !== 1'b0) $display("FAIL ovf_timeout: got %0b want 0", to); else passed++;
        checks++; if (done_o !== 1'b1) $display("FAIL ovf_done: got %0b want 1", done_o); else passed++;
        checks++; if (ovf_o !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", ovf_o); else passed++;
        checks++; if (runs - r0 !== 2) $display("FAIL ovf_runs: got %0d want 2", runs - r0); else passed++;
        checks++; if (we_cnt - w0 !== 16) $display("FAIL ovf_we: got %0d want 16", we_cnt - w0); else passed++;
        checks++; if (addr_o !== 10'd15) $display("FAIL ovf_addr: got %0d want 15", addr_o); else passed++;
        check_stops("ovf", r0);
        wpr = 1;
        start_scan(1'b1, 8'd0, 8'd9, 8'd1, 8'd1, 8'd1);
        wait_end(500, to);
        checks++; if (ovf_o !== 1'b0) $display("FAIL ovf_cleared: got %0b want 0", ovf_o); else passed++;
        checks++; if (addr_o !== 10'd1) $display("FAIL ovf_restart_addr: got %0d want 1", addr_o); else passed++;
    endtask

    task automatic test_abort;
        int r0 = runs;
        bit to;
        wpr = 2;
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd10);
        start_scan(1'b0, 8'd0, 8'd10, 8'd5, 8'd3, 8'd2);
        wait_runs(r0 + 2, 500, to);
        checks++; if (to !== 1'b0) $display("FAIL abort_reach: got %0b want 0", to); else passed++;
        @(negedge clk);
        scan_abort = 1'b1;
        @(negedge clk);
        scan_abort = 1'b0;
        wait_end(1000, to);
        checks++; if (done_o !== 1'b1) $display("FAIL abort_done: got %0b want 1", done_o); else passed++;
        checks++; if (runs - r0 !== 2) $display("FAIL abort_runs: got %0d want 2", runs - r0); else passed++;
        checks++; if (addr_o !== 10'd4) $display("FAIL abort_addr: got %0d want 4", addr_o); else passed++;
        check_stops("abort", r0);
    endtask

    task automatic test_busy_start;
        int r0 = runs;
        bit to;
        wpr = 4;
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd40);
        start_scan(1'b0, 8'd1, 8'd40, 8'd0, 8'd1, 8'd2);
        wait_runs(r0 + 1, 200, to);
        tick(3);
        start_scan(1'b0, 8'd1, 8'd40, 8'd0, 8'd5, 8'd2);
        wait_end(1000, to);
        checks++; if (done_o !== 1'b1) $display("FAIL busy_done: got %0b want 1", done_o); else passed++;
        checks++; if (runs - r0 !== 2) $display("FAIL busy_runs: got %0d want 2", runs - r0); else passed++;
        checks++; if (addr_o !== 10'd8) $display("FAIL busy_addr: got %0d want 8", addr_o); else passed++;
        check_stops("busy", r0);
    endtask

    task automatic test_back_to_back;
        int r0 = runs;
        bit to;
        wpr = 1;
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd107);
        start_scan(1'b0, 8'd0, 8'd7, 8'd100, 8'd2, 8'd1);
        wait_end(500, to);
        checks++; if (done_o !== 1'b1) $display("FAIL b2b_done: got %0b want 1", done_o); else passed++;
        checks++; if (addr_o !== 10'd2) $display("FAIL b2b_addr: got %0d want 2", addr_o); else passed++;
        check_stops("b2b", r0);
    endtask

    task automatic test_timeout;
        int r0 = runs;
        bit to;
        hang = 1'b1;
        start_scan(1'b0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1);
        wait_end(1300, to);
        checks++; if (to !== 1'b0) $display("FAIL tmo_wait: got %0b want 0", to); else passed++;
        checks++; if (err_o !== 1'b1) $display("FAIL tmo_error: got %0b want 1", err_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL tmo_busy: got %0b want 0", busy_o); else passed++;
        checks++; if (done_o !== 1'b0) $display("FAIL tmo_done: got %0b want 0", done_o); else passed++;
        tick(20);
        checks++; if (runs - r0 !== 1) $display("FAIL tmo_runs: got %0d want 1", runs - r0); else passed++;
        checks++; if (run_o !== 1'b0) $display("FAIL tmo_run: got %0b want 0", run_o); else passed++;
        hang = 1'b0;
        tick(3);
        wpr = 2;
        start_scan(1'b0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1);
        wait_end(500, to);
        checks++; if (err_o !== 1'b0) $display("FAIL tmo_recover_err: got %0b want 0", err_o); else passed++;
        checks++; if (addr_o !== 10'd2) $display("FAIL tmo_recover_addr: got %0d want 2", addr_o); else passed++;
    endtask

    task automatic test_reset_mid;
        int r0 = runs;
        int w0;
        bit to;
        wpr = 8;
        start_scan(1'b0, 8'd5, 8'd10, 8'd5, 8'd2, 8'd1);
        wait_runs(r0 + 1, 200, to);
        tick(4);
        @(negedge clk);
        reset = 1'b1;
        w0 = we_cnt;
        @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy_o); else passed++;
        checks++; if (run_o !== 1'b0) $display("FAIL mid_run: got %0b want 0", run_o); else passed++;
        checks++; if (we_o !== 1'b0) $display("FAIL mid_we: got %0b want 0", we_o); else passed++;
        checks++; if (addr_o !== 10'd0) $display("FAIL mid_addr: got %0d want 0", addr_o); else passed++;
        checks++; if (tsp_o !== 8'd0) $display("FAIL mid_tstop: got %0d want 0", tsp_o); else passed++;
        checks++; if (tst_o !== 8'd0) $display("FAIL mid_tstart: got %0d want 0", tst_o); else passed++;
        @(negedge clk);
        reset = 1'b0;
        r0 = runs;
        tick(5);
        checks++; if (we_cnt - w0 !== 0) $display("FAIL mid_trail_we: got %0d want 0", we_cnt - w0); else passed++;
        checks++; if (runs - r0 !== 0) $display("FAIL mid_trail_run: got %0d want 0", runs - r0); else passed++;
        wpr = 3;
        start_scan(1'b0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1);
        wait_end(500, to);
        checks++; if (done_o !== 1'b1) $display("FAIL mid_restart_done: got %0b want 1", done_o); else passed++;
        checks++; if (addr_o !== 10'd3) $display("FAIL mid_restart_addr: got %0d want 3", addr_o); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        scan_abort = 1'b0;
        sel = 1'b0;
        wpr = 8;
        hang = 1'b0;
        t_start_base = '0;
        t_stop_first = '0;
        t_stop_step = '0;
        n_steps = '0;
        n_repeats = '0;
        test_reset;
        test_grid;
        test_wrap;
        test_overflow;
        test_abort;
        test_busy_start;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
